// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state type and address helper for the framebuffer arbiter.
package vga_pkg;

  localparam int unsigned H_ACTIVE       = 640;
  localparam int unsigned H_TOTAL        = 800;
  localparam int unsigned V_ACTIVE       = 480;
  localparam int unsigned V_TOTAL        = 525;
  localparam int unsigned PIX_PER_WORD   = 16;
  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / PIX_PER_WORD;
  localparam int unsigned ADDR_W         = 15;
  localparam int unsigned DATA_W         = 3 * PIX_PER_WORD;
  localparam int unsigned CPU_SLOT_EVERY = 8;
  localparam int unsigned CNT_W          = 10;
  localparam int unsigned WORD_W         = 6;
  localparam int unsigned SLOT_W         = 4;
  localparam int unsigned FB_WORDS       = V_ACTIVE * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2
  } fb_state_t;

  // First RAM word of a visible line.
  function automatic logic [ADDR_W-1:0] line_base(input logic [CNT_W-1:0] line);
    return ADDR_W'(line) * ADDR_W'(WORDS_PER_LINE);
  endfunction

endpackage

// File: rtl/vga_fetch_trigger.sv
// Decodes the timing counters into a prefetch trigger and the line to be fetched.
module vga_fetch_trigger
  import vga_pkg::*;
(
  input  logic [CNT_W-1:0] hcnt,
  input  logic [CNT_W-1:0] vcnt,
  output logic             trigger,
  output logic [CNT_W-1:0] target_line
);

  // Fire at the start of horizontal blank on lines followed by a visible line.
  always_comb begin
    trigger     = 1'b0;
    target_line = '0;
    if (hcnt == CNT_W'(H_ACTIVE)) begin
      if (vcnt < CNT_W'(V_ACTIVE - 1)) begin
        trigger     = 1'b1;
        target_line = vcnt + CNT_W'(1);
      end else if (vcnt == CNT_W'(V_TOTAL - 1)) begin
        trigger     = 1'b1;
        target_line = '0;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanline prefetch into the line buffer with guaranteed CPU write slots.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcnt,
  input  logic [CNT_W-1:0]  vcnt,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [WORD_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              fetch_underrun
);

  fb_state_t         state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              bank_q, bank_d;
  logic              rd_pend_q, rd_pend_d;
  logic [WORD_W-1:0] rd_word_q, rd_word_d;
  logic              underrun_q, underrun_d;

  logic              trigger;
  logic [CNT_W-1:0]  target_line;
  logic              abort;
  logic              cpu_write;

  vga_fetch_trigger u_trigger (
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .trigger     (trigger),
    .target_line (target_line)
  );

  assign fetch_underrun = underrun_q;

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      slot_q     <= '0;
      base_q     <= '0;
      bank_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_word_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      slot_q     <= slot_d;
      base_q     <= base_d;
      bank_q     <= bank_d;
      rd_pend_q  <= rd_pend_d;
      rd_word_q  <= rd_word_d;
      underrun_q <= underrun_d;
    end
  end

  // Next-state, RAM grant and line-buffer write decode; an end-of-line abort drops any pending read.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    slot_d     = slot_q;
    base_d     = base_q;
    bank_d     = bank_q;
    rd_pend_d  = 1'b0;
    rd_word_d  = rd_word_q;
    underrun_d = underrun_q;
    cpu_ready  = 1'b0;
    cpu_write  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lb_we      = 1'b0;
    lb_bank    = 1'b0;
    lb_addr    = '0;
    lb_data    = '0;
    abort      = (state_q != IDLE) && (hcnt == CNT_W'(H_TOTAL - 1));

    if (!rst) begin
      if (rd_pend_q && !abort) begin
        lb_we   = 1'b1;
        lb_bank = bank_q;
        lb_addr = rd_word_q;
        lb_data = mem_rdata;
      end

      case (state_q)
        IDLE: begin
          cpu_ready = 1'b1;
          cpu_write = cpu_valid;
          if (trigger) begin
            state_d = FETCH;
            word_d  = '0;
            slot_d  = '0;
            base_d  = line_base(target_line);
            bank_d  = target_line[0];
          end
        end
        FETCH: begin
          if (abort) begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end else if (slot_q == SLOT_W'(CPU_SLOT_EVERY) && cpu_valid) begin
            cpu_ready = 1'b1;
            cpu_write = 1'b1;
            slot_d    = '0;
          end else begin
            mem_en    = 1'b1;
            mem_addr  = base_q + ADDR_W'(word_q);
            rd_pend_d = 1'b1;
            rd_word_d = word_q;
            word_d    = word_q + WORD_W'(1);
            if (slot_q != SLOT_W'(CPU_SLOT_EVERY)) begin
              slot_d = slot_q + SLOT_W'(1);
            end
            if (word_q == WORD_W'(WORDS_PER_LINE - 1)) begin
              state_d = LAST;
            end
          end
        end
        LAST: begin
          state_d = IDLE;
          if (abort) begin
            underrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      // Out-of-range CPU writes are acknowledged but never reach the RAM.
      if (cpu_write && (cpu_addr < ADDR_W'(FB_WORDS))) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter with a behavioural RAM returning an address-derived pattern.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcnt, vcnt;
  logic        cpu_valid, cpu_ready;
  logic [14:0] cpu_addr;
  logic [47:0] cpu_wdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata = '0;
  logic        lb_we, lb_bank;
  logic [5:0]  lb_addr;
  logic [47:0] lb_data;
  logic        fetch_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  vga_fb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .hcnt           (hcnt),
    .vcnt           (vcnt),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .lb_we          (lb_we),
    .lb_bank        (lb_bank),
    .lb_addr        (lb_addr),
    .lb_data        (lb_data),
    .fetch_underrun (fetch_underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pat(input logic [14:0] a);
    return {3'b101, a, a ^ 15'h5555, a + 15'h0f0f};
  endfunction

  // RAM model: read data appears one cycle after the read.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger a fetch and check every cycle until the FSM is back in IDLE.
  task automatic run_fetch(input logic [9:0] v, input int base, input logic bank, input logic cpu_on);
    int  nwr = 0;
    bit  prev_rd = 0;
    int  prev_word = 0;
    int  last;
    bit  is_wr;
    last = cpu_on ? 44 : 40;
    hcnt = 10'd640; vcnt = v; cpu_valid = 1'b0;
    @(negedge clk);
    check("trig_cycle_ready", 64'(cpu_ready), 64'(1));
    tick();
    for (int c = 0; c <= last + 1; c++) begin
      hcnt      = 10'(641 + c);
      cpu_valid = cpu_on;
      cpu_addr  = 15'(16384 + c);
      cpu_wdata = 48'hABC000 + 48'(c);
      is_wr     = cpu_on && (c == 8 || c == 17 || c == 26 || c == 35);
      @(negedge clk);
      if (c < last) begin
        if (is_wr) begin
          check($sformatf("slot_ready c%0d", c), 64'(cpu_ready), 64'(1));
          check($sformatf("slot_we c%0d", c), 64'({mem_en, mem_we}), 64'(3));
          check($sformatf("slot_addr c%0d", c), 64'(mem_addr), 64'(16384 + c));
          check($sformatf("slot_wdata c%0d", c), 64'(mem_wdata), 64'(48'hABC000 + 48'(c)));
        end else begin
          check($sformatf("rd_en c%0d", c), 64'({mem_en, mem_we, cpu_ready}), 64'(4));
          check($sformatf("rd_addr c%0d", c), 64'(mem_addr), 64'(base + c - nwr));
        end
      end else if (c == last) begin
        check("last_idle_bus", 64'({mem_en, cpu_ready}), 64'(0));
      end else begin
        check("back_idle_ready", 64'(cpu_ready), 64'(1));
        check("back_idle_en", 64'(mem_en), 64'(cpu_on));
      end
      check($sformatf("lb_we c%0d", c), 64'(lb_we), 64'(prev_rd));
      if (prev_rd) begin
        check($sformatf("lb_addr c%0d", c), 64'(lb_addr), 64'(prev_word));
        check($sformatf("lb_bank c%0d", c), 64'(lb_bank), 64'(bank));
        check($sformatf("lb_data c%0d", c), 64'(lb_data), 64'(pat(15'(base + prev_word))));
      end
      prev_rd   = (c < last) && !is_wr;
      prev_word = c - nwr;
      if (is_wr) nwr++;
      tick();
    end
    cpu_valid = 1'b0;
    hcnt      = 10'd100;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hcnt = 10'd100; vcnt = 10'd500;
    cpu_valid = 1'b1; cpu_addr = 15'h0123; cpu_wdata = 48'h1234_5678_9abc;

    repeat (3) begin
      @(negedge clk);
      check("rst_outputs", 64'({cpu_ready, mem_en, lb_we, fetch_underrun}), 64'(0));
    end
    tick();
    rst = 1'b0;

    // Idle CPU write
    @(negedge clk);
    check("idle_ready", 64'(cpu_ready), 64'(1));
    check("idle_we", 64'({mem_en, mem_we}), 64'(3));
    check("idle_addr", 64'(mem_addr), 64'(15'h0123));
    check("idle_wdata", 64'(mem_wdata), 64'(48'h1234_5678_9abc));
    tick();

    // Out-of-range address boundary
    cpu_addr = 15'd19200;
    @(negedge clk);
    check("oob_ready", 64'(cpu_ready), 64'(1));
    check("oob_dropped", 64'(mem_en), 64'(0));
    tick();
    cpu_addr = 15'd19199;
    @(negedge clk);
    check("top_addr_en", 64'(mem_en), 64'(1));
    tick();
    cpu_valid = 1'b0;

    run_fetch(10'd4, 200, 1'b1, 1'b0);
    run_fetch(10'd524, 0, 1'b0, 1'b0);

    // Last visible line: no fetch
    hcnt = 10'd640; vcnt = 10'd479;
    tick();
    for (int c = 0; c < 3; c++) begin
      hcnt = 10'(641 + c);
      @(negedge clk);
      check("no_fetch_479", 64'({cpu_ready, mem_en, lb_we}), 64'(4));
      tick();
    end

    run_fetch(10'd9, 400, 1'b0, 1'b1);

    // Underrun: counter jumps to end of line during a fetch
    hcnt = 10'd640; vcnt = 10'd20;
    tick();
    hcnt = 10'd700;
    repeat (3) tick();
    hcnt = 10'd799;
    @(negedge clk);
    check("abort_cycle", 64'({lb_we, mem_en, cpu_ready, fetch_underrun}), 64'(0));
    tick();
    hcnt = 10'd0;
    @(negedge clk);
    check("after_abort", 64'({cpu_ready, lb_we, fetch_underrun}), 64'(5));
    tick();
    repeat (5) tick();
    @(negedge clk);
    check("underrun_sticky", 64'(fetch_underrun), 64'(1));

    // Reset mid-fetch
    hcnt = 10'd640; vcnt = 10'd30;
    tick();
    hcnt = 10'd650;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_fetch", 64'({lb_we, mem_en, cpu_ready}), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst", 64'({cpu_ready, lb_we, fetch_underrun}), 64'(4));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
